// File: rtl/vga_csr_bank.sv
// Control/status register bank for the VGA timing generator and scanout path.
// Latency: read data appears one cycle after read_en_i; staged writes reach the live outputs at the next frame boundary.
// No backpressure: every strobe is accepted. Optional interrupt logic is built when VGA_CSR_IRQ_EN is defined.
module vga_csr_bank #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] addr_write_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              read_en_i,
  input  logic [ADDR_W-1:0] addr_read_i,
  output logic [DATA_W-1:0] data_o,
  input  logic              frame_start_i,
  output logic              enable_o,
  output logic              test_pattern_o,
  output logic [11:0]       h_active_o,
  output logic [11:0]       h_total_o,
  output logic [11:0]       v_active_o,
  output logic [11:0]       v_total_o,
  output logic [31:0]       fb_base_o,
  output logic              irq_o
);

  // Register map, in word addresses
  localparam logic [ADDR_W-1:0] A_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_HTIM     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_VTIM     = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_FB_BASE  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_STATUS   = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_IRQ_STAT = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_IRQ_MASK = ADDR_W'(6);

  // Reset geometry: 640x480 active inside an 800x525 total raster
  localparam logic [11:0] RST_H_ACTIVE = 12'h280;
  localparam logic [11:0] RST_H_TOTAL  = 12'h320;
  localparam logic [11:0] RST_V_ACTIVE = 12'h1E0;
  localparam logic [11:0] RST_V_TOTAL  = 12'h20D;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Staged copies: written by software, read back by software
  logic        stg_enable, stg_test_pattern;
  logic [11:0] stg_h_active, stg_h_total, stg_v_active, stg_v_total;
  logic [31:0] stg_fb_base;

  // Live copies: what the timing generator and scanout actually use
  logic        live_enable, live_test_pattern;
  logic [11:0] live_h_active, live_h_total, live_v_active, live_v_total;
  logic [31:0] live_fb_base;

  logic [15:0]       frame_cnt;
  logic [DATA_W-1:0] rd_mux;

  logic wr_ctrl, wr_htim, wr_vtim, wr_fb, wr_staged;
  logic commit, pending, frame_tick;

  assign wr_ctrl   = write_en_i && (addr_write_i == A_CTRL);
  assign wr_htim   = write_en_i && (addr_write_i == A_HTIM);
  assign wr_vtim   = write_en_i && (addr_write_i == A_VTIM);
  assign wr_fb     = write_en_i && (addr_write_i == A_FB_BASE);
  assign wr_staged = wr_ctrl || wr_htim || wr_vtim || wr_fb;

  assign pending    = (state == PEND);
  // Frames only count while the generator is actually running
  assign frame_tick = frame_start_i && live_enable;

  // Commit state register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Commit decision: wait for a frame boundary unless the generator is stopped.
  // A write landing on the commit cycle keeps the bank pending for the next boundary.
  always_comb begin
    state_nxt = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (wr_staged) state_nxt = PEND;
      end
      PEND: begin
        if (frame_start_i || !live_enable) begin
          commit = 1'b1;
          if (!wr_staged) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Staged registers take software writes; unused bits are dropped
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      stg_enable       <= 1'b0;
      stg_test_pattern <= 1'b0;
      stg_h_active     <= RST_H_ACTIVE;
      stg_h_total      <= RST_H_TOTAL;
      stg_v_active     <= RST_V_ACTIVE;
      stg_v_total      <= RST_V_TOTAL;
      stg_fb_base      <= 32'h0;
    end else begin
      if (wr_ctrl) begin
        stg_enable       <= data_i[0];
        stg_test_pattern <= data_i[1];
      end
      if (wr_htim) begin
        stg_h_active <= data_i[11:0];
        stg_h_total  <= data_i[27:16];
      end
      if (wr_vtim) begin
        stg_v_active <= data_i[11:0];
        stg_v_total  <= data_i[27:16];
      end
      if (wr_fb) begin
        stg_fb_base <= data_i[31:0];
      end
    end
  end

  // Live registers copy the pre-write staged values on commit
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      live_enable       <= 1'b0;
      live_test_pattern <= 1'b0;
      live_h_active     <= RST_H_ACTIVE;
      live_h_total      <= RST_H_TOTAL;
      live_v_active     <= RST_V_ACTIVE;
      live_v_total      <= RST_V_TOTAL;
      live_fb_base      <= 32'h0;
    end else if (commit) begin
      live_enable       <= stg_enable;
      live_test_pattern <= stg_test_pattern;
      live_h_active     <= stg_h_active;
      live_h_total      <= stg_h_total;
      live_v_active     <= stg_v_active;
      live_v_total      <= stg_v_total;
      live_fb_base      <= stg_fb_base;
    end
  end

  // Free-running frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      frame_cnt <= 16'h0;
    end else if (frame_tick) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

`ifdef VGA_CSR_IRQ_EN
  logic irq_stat, irq_mask;
  logic wr_irq_stat, wr_irq_mask;

  assign wr_irq_stat = write_en_i && (addr_write_i == A_IRQ_STAT);
  assign wr_irq_mask = write_en_i && (addr_write_i == A_IRQ_MASK);

  // Frame interrupt: set on a counted frame, write-1-to-clear, set beats clear
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      irq_stat <= 1'b0;
      irq_mask <= 1'b0;
    end else begin
      if (frame_tick) begin
        irq_stat <= 1'b1;
      end else if (wr_irq_stat && data_i[0]) begin
        irq_stat <= 1'b0;
      end
      if (wr_irq_mask) begin
        irq_mask <= data_i[0];
      end
    end
  end

  assign irq_o = irq_stat & irq_mask;
`else
  assign irq_o = 1'b0;
`endif

  // Read mux: staged values are returned, never the live ones
  always_comb begin
    rd_mux = '0;
    case (addr_read_i)
      A_CTRL:     rd_mux = DATA_W'({30'h0, stg_test_pattern, stg_enable});
      A_HTIM:     rd_mux = DATA_W'({4'h0, stg_h_total, 4'h0, stg_h_active});
      A_VTIM:     rd_mux = DATA_W'({4'h0, stg_v_total, 4'h0, stg_v_active});
      A_FB_BASE:  rd_mux = DATA_W'(stg_fb_base);
      A_STATUS:   rd_mux = DATA_W'({15'h0, pending, frame_cnt});
`ifdef VGA_CSR_IRQ_EN
      A_IRQ_STAT: rd_mux = DATA_W'({31'h0, irq_stat});
      A_IRQ_MASK: rd_mux = DATA_W'({31'h0, irq_mask});
`endif
      default:    rd_mux = '0;
    endcase
  end

  // Read data register: loads on a read strobe and holds otherwise
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      data_o <= '0;
    end else if (read_en_i) begin
      data_o <= rd_mux;
    end
  end

  assign enable_o       = live_enable;
  assign test_pattern_o = live_test_pattern;
  assign h_active_o     = live_h_active;
  assign h_total_o      = live_h_total;
  assign v_active_o     = live_v_active;
  assign v_total_o      = live_v_total;
  assign fb_base_o      = live_fb_base;

endmodule

// File: tb/tb_vga_csr_bank.sv
// Bench for vga_csr_bank: a register-array model checked against the DUT on every
// falling edge, plus literal expectations from the register map.
// Build with VGA_CSR_IRQ_EN defined to exercise the interrupt path.
module tb_vga_csr_bank;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        write_en = 1'b0;
  logic [3:0]  addr_write = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic        read_en = 1'b0;
  logic [3:0]  addr_read = 4'h0;
  logic [31:0] data_out;
  logic        frame_start = 1'b0;
  logic        enable, test_pattern, irq;
  logic [11:0] h_active, h_total, v_active, v_total;
  logic [31:0] fb_base;

  int checks = 0;
  int failures = 0;

  vga_csr_bank #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk_i(clk), .arst_i(arst),
    .write_en_i(write_en), .addr_write_i(addr_write), .data_i(data_in),
    .read_en_i(read_en), .addr_read_i(addr_read), .data_o(data_out),
    .frame_start_i(frame_start),
    .enable_o(enable), .test_pattern_o(test_pattern),
    .h_active_o(h_active), .h_total_o(h_total),
    .v_active_o(v_active), .v_total_o(v_total),
    .fb_base_o(fb_base), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // ---------------- model: register words indexed by address ----------------
  logic [31:0] m_stg [4];
  logic [31:0] m_live [4];
  logic        m_pend;
  logic [15:0] m_fcnt;
  logic        m_irq, m_mask;
  logic [31:0] m_data;

  function automatic logic [31:0] wmask(input int a);
    case (a)
      0: return 32'h0000_0003;
      1, 2: return 32'h0FFF_0FFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] model_rd(input logic [3:0] a);
    if (a < 4) return m_stg[a[1:0]];
    if (a == 4) return {15'h0, m_pend, m_fcnt};
`ifdef VGA_CSR_IRQ_EN
    if (a == 5) return {31'h0, m_irq};
    if (a == 6) return {31'h0, m_mask};
`endif
    return 32'h0;
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_stg[0] = 32'h0; m_stg[1] = 32'h0320_0280; m_stg[2] = 32'h020D_01E0; m_stg[3] = 32'h0;
      for (int i = 0; i < 4; i++) m_live[i] = m_stg[i];
      m_pend = 1'b0; m_fcnt = 16'h0; m_irq = 1'b0; m_mask = 1'b0; m_data = 32'h0;
    end else begin
      logic running, do_commit;
      running = m_live[0][0];
      // read sees everything as it was before this edge
      if (read_en) m_data = model_rd(addr_read);
      do_commit = m_pend && (frame_start || !running);
      if (do_commit) for (int i = 0; i < 4; i++) m_live[i] = m_stg[i];
      if (frame_start && running) m_fcnt = m_fcnt + 16'd1;
`ifdef VGA_CSR_IRQ_EN
      if (frame_start && running) m_irq = 1'b1;
      else if (write_en && addr_write == 4'd5 && data_in[0]) m_irq = 1'b0;
      if (write_en && addr_write == 4'd6) m_mask = data_in[0];
`endif
      if (write_en && addr_write < 4) begin
        m_stg[addr_write[1:0]] = data_in & wmask(int'(addr_write));
        m_pend = 1'b1;
      end else if (do_commit) begin
        m_pend = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Every falling edge: all outputs against the model
  always @(negedge clk) begin
    check("enable_o", 32'(enable), 32'(m_live[0][0]));
    check("test_pattern_o", 32'(test_pattern), 32'(m_live[0][1]));
    check("h_active_o", 32'(h_active), 32'(m_live[1][11:0]));
    check("h_total_o", 32'(h_total), 32'(m_live[1][27:16]));
    check("v_active_o", 32'(v_active), 32'(m_live[2][11:0]));
    check("v_total_o", 32'(v_total), 32'(m_live[2][27:16]));
    check("fb_base_o", fb_base, m_live[3]);
    check("data_o", data_out, m_data);
    check("irq_o", 32'(irq), 32'(m_irq & m_mask));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    write_en = 1'b1; addr_write = a; data_in = d;
    step();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    read_en = 1'b1; addr_read = a;
    step();
    read_en = 1'b0;
  endtask

  task automatic pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  initial begin
    #12 arst = 1'b0;
    step();
    check("rst enable", 32'(enable), 32'h0);
    check("rst irq", 32'(irq), 32'h0);
    check("rst h_active", 32'(h_active), 32'h280);
    check("rst v_total", 32'(v_total), 32'h20D);
    rd(4'd1); check("rd HTIM rst", data_out, 32'h0320_0280);
    rd(4'd2); check("rd VTIM rst", data_out, 32'h020D_01E0);

    // generator stopped: commit on the following edge, no frame pulse needed
    wr(4'd1, 32'hF400_F300);
    check("h_active before commit", 32'(h_active), 32'h280);
    step();
    check("h_active committed", 32'(h_active), 32'h300);
    check("h_total committed", 32'(h_total), 32'h400);
    rd(4'd1); check("rd HTIM masked", data_out, 32'h0400_0300);

    // start the generator, then stage a frame buffer change
    wr(4'd0, 32'h1);
    step();
    check("enable on", 32'(enable), 32'h1);
    wr(4'd3, 32'h0000_1000);
    step(); step();
    check("fb held", fb_base, 32'h0);
    rd(4'd4); check("status pending", data_out, 32'h0001_0000);
    pulse();
    check("fb at frame", fb_base, 32'h0000_1000);
    rd(4'd4); check("status after frame", data_out, 32'h0000_0001);

    // write coincident with frame start: old staged value goes live
    write_en = 1'b1; addr_write = 4'd3; data_in = 32'h0000_2000;
    read_en = 1'b1; addr_read = 4'd3; frame_start = 1'b1;
    step();
    write_en = 1'b0; read_en = 1'b0; frame_start = 1'b0;
    check("rd same-cycle old", data_out, 32'h0000_1000);
    check("fb unchanged", fb_base, 32'h0000_1000);
    rd(4'd4); check("status still pending", data_out, 32'h0001_0002);
    pulse();
    check("fb next frame", fb_base, 32'h0000_2000);

`ifdef VGA_CSR_IRQ_EN
    wr(4'd6, 32'h1);
    pulse();
    check("irq set", 32'(irq), 32'h1);
    write_en = 1'b1; addr_write = 4'd5; data_in = 32'h1; frame_start = 1'b1;
    step();
    write_en = 1'b0; frame_start = 1'b0;
    check("irq set wins", 32'(irq), 32'h1);
    wr(4'd5, 32'h1);
    check("irq cleared", 32'(irq), 32'h0);
`else
    wr(4'd6, 32'h1);
    rd(4'd6); check("rd unmapped 6", data_out, 32'h0);
    rd(4'd4); check("status not pending", data_out[16], 1'b0);
`endif

    // async reset while a write is pending
    wr(4'd3, 32'h0000_3000);
    #3 arst = 1'b1;
    #1;
    check("arst fb", fb_base, 32'h0);
    check("arst h_active", 32'(h_active), 32'h280);
    check("arst enable", 32'(enable), 32'h0);
    #2 arst = 1'b0;
    step();
    rd(4'd3); check("arst staged lost", data_out, 32'h0);
    rd(4'd4); check("arst status", data_out, 32'h0);

    // frame counter wrap
    wr(4'd0, 32'h1);
    step();
    frame_start = 1'b1;
    repeat (65536) step();
    frame_start = 1'b0;
    rd(4'd4); check("frame_cnt wrap", data_out, 32'h0);
    rd(4'd1); check("rd HTIM", data_out, 32'h0320_0280);
    rd(4'hF); check("rd unmapped F", data_out, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
